// File: rtl/issue_select_pkg.sv
// Issue-select package: pulls in the shared machine types and adds lane/RS sizes plus a
// mask-clearing helper used for both newly latched and held lane packets.
package issue_select_pkg;
  `include "sys_defs.svh"

  localparam int NUM_LANES = `N;
  localparam int RS_SIZE   = `RS_SZ;

  function automatic RS_PACKET clear_masks(input RS_PACKET p, input B_MASK_MASK b_clr,
                                           input SQ_MASK sq_clr);
    RS_PACKET r;
    r         = p;
    r.b_mask  = p.b_mask & ~b_clr;
    r.sq_mask = p.sq_mask & ~sq_clr;
    return r;
  endfunction
endpackage

// File: rtl/issue_rr_arb.sv
// Multi-grant selector: each free slot, lowest first, takes the next request in priority order.
// ISSUE_RR_PRIORITY_EN adds a rotating start pointer; otherwise priority is fixed, lowest index first.
module issue_rr_arb #(
  parameter  int WIDTH = `RS_SZ,
  parameter  int REQS  = `N,
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
`ifdef ISSUE_RR_PRIORITY_EN
  input  logic                       clock,
  input  logic                       reset,
`endif
  input  logic [WIDTH-1:0]           req,
  input  logic [REQS-1:0]            slot_free,
  output logic [WIDTH-1:0]           grant,
  output logic [REQS-1:0]            slot_valid,
  output logic [REQS-1:0][IDX_W-1:0] slot_idx
);

  logic [IDX_W-1:0] rr_ptr;
  logic [WIDTH-1:0] remaining;
  logic [IDX_W-1:0] cand;
  int               pos;

`ifdef ISSUE_RR_PRIORITY_EN
  logic [IDX_W-1:0] rr_ptr_next;

  // The highest granting slot holds the grant furthest along the priority order.
  always_comb begin
    rr_ptr_next = rr_ptr;
    for (int k = 0; k < REQS; k++) begin
      if (slot_valid[k]) begin
        rr_ptr_next = (slot_idx[k] == IDX_W'(WIDTH - 1)) ? '0 : slot_idx[k] + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) rr_ptr <= '0;
    else       rr_ptr <= rr_ptr_next;
  end
`else
  assign rr_ptr = '0;
`endif

  // NOTE: every variable written here gets a default first, so no path can infer a latch.
  always_comb begin
    grant      = '0;
    slot_valid = '0;
    slot_idx   = '0;
    remaining  = req;
    cand       = '0;
    pos        = 0;
    for (int k = 0; k < REQS; k++) begin
      if (slot_free[k]) begin
        for (int i = 0; i < WIDTH; i++) begin
          pos = int'(rr_ptr) + i;
          if (pos >= WIDTH) pos = pos - WIDTH;
          cand = IDX_W'(pos);
          if (!slot_valid[k] && remaining[cand]) begin
            slot_valid[k] = 1'b1;
            slot_idx[k]   = cand;
          end
        end
        if (slot_valid[k]) begin
          remaining[slot_idx[k]] = 1'b0;
          grant[slot_idx[k]]     = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/sys_defs.svh
// Shared machine definitions: lane count, RS depth, mask widths and the RS/issue packet types.
`ifndef SYS_DEFS_SVH
`define SYS_DEFS_SVH

`define N            2
`define RS_SZ        8
`define SQ_SZ        8
`define B_MASK_WIDTH 4

typedef logic [`SQ_SZ-1:0]        SQ_MASK;
typedef logic [`B_MASK_WIDTH-1:0] B_MASK_MASK;

typedef struct packed {
  logic [31:0] inst;
  logic [5:0]  dest_tag;
  logic        Source1_ready;
  logic        Source2_ready;
  logic        rd_mem;
  SQ_MASK      sq_mask;
  B_MASK_MASK  b_mask;
} RS_PACKET;

typedef struct packed {
  logic     valid;
  RS_PACKET packet;
} ISSUE_LANE;

`endif

// File: rtl/issue_select.sv
// RS issue stage: picks ready entries into free execute lanes with one-cycle latency, and keeps
// held lanes' branch/store masks current. ISSUE_RR_PRIORITY_EN selects round-robin entry priority.
module issue_select
  import issue_select_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  RS_PACKET          rs_data_next [`RS_SZ],
  input  logic [`RS_SZ-1:0] rs_valid_issue,
  input  SQ_MASK            resolving_sq_mask,
  input  B_MASK_MASK        b_mm_resolve,
  input  logic              b_mm_mispred,
  input  logic [`N-1:0]     ex_ready,
  output logic [`RS_SZ-1:0] rs_data_issuing,
  output RS_PACKET          issue_packets [`N],
  output logic [`N-1:0]     issue_valid
);

  localparam int IDX_W = (`RS_SZ > 1) ? $clog2(`RS_SZ) : 1;

  ISSUE_LANE                 lanes      [`N];
  ISSUE_LANE                 lanes_next [`N];
  logic [`RS_SZ-1:0]         ready;
  logic [`RS_SZ-1:0]         req;
  logic [`N-1:0]             lane_free;
  logic [`N-1:0]             slot_valid;
  logic [`N-1:0][IDX_W-1:0]  slot_idx;

  // Loads wait until every older store they depend on has resolved, counting this cycle's.
  always_comb begin
    for (int j = 0; j < `RS_SZ; j++) begin
      ready[j] = rs_valid_issue[j] & rs_data_next[j].Source1_ready
               & rs_data_next[j].Source2_ready
               & (!rs_data_next[j].rd_mem
                  | ((rs_data_next[j].sq_mask & ~resolving_sq_mask) == '0));
    end
  end

  assign req = reset ? '0 : ready;

  always_comb begin
    for (int k = 0; k < `N; k++) begin
      lane_free[k] = !lanes[k].valid | ex_ready[k];
    end
  end

  issue_rr_arb #(
    .WIDTH (`RS_SZ),
    .REQS  (`N)
  ) u_arb (
`ifdef ISSUE_RR_PRIORITY_EN
    .clock      (clock),
    .reset      (reset),
`endif
    .req        (req),
    .slot_free  (lane_free),
    .grant      (rs_data_issuing),
    .slot_valid (slot_valid),
    .slot_idx   (slot_idx)
  );

  // A free lane without a grant, or a held lane squashed by a mispredicting branch, empties.
  always_comb begin
    for (int k = 0; k < `N; k++) begin
      lanes_next[k] = '0;
      if (slot_valid[k]) begin
        lanes_next[k].valid  = 1'b1;
        lanes_next[k].packet = clear_masks(rs_data_next[slot_idx[k]], '0, resolving_sq_mask);
      end else if (!lane_free[k]
                   && !(b_mm_mispred && ((lanes[k].packet.b_mask & b_mm_resolve) != '0))) begin
        lanes_next[k].valid  = 1'b1;
        lanes_next[k].packet = clear_masks(lanes[k].packet, b_mm_resolve, resolving_sq_mask);
      end
    end
  end

  // NOTE: lane registers are few and architecturally visible, so they are reset (not left as
  // uninitialised storage) and updated with non-blocking assignments only.
  always_ff @(posedge clock) begin
    for (int k = 0; k < `N; k++) begin
      if (reset) lanes[k] <= '0;
      else       lanes[k] <= lanes_next[k];
    end
  end

  always_comb begin
    for (int k = 0; k < `N; k++) begin
      issue_packets[k] = lanes[k].packet;
      issue_valid[k]   = lanes[k].valid;
    end
  end

endmodule

// File: tb/tb_issue_select.sv
// Directed bench for issue_select (2 lanes, 8 RS entries); expectations follow the active
// priority mode selected by ISSUE_RR_PRIORITY_EN.
module tb_issue_select;
  import issue_select_pkg::*;

`ifdef ISSUE_RR_PRIORITY_EN
  localparam bit RR_MODE = 1'b1;
`else
  localparam bit RR_MODE = 1'b0;
`endif

  logic                   clock = 1'b0;
  logic                   reset;
  RS_PACKET               rs_data_next [RS_SIZE];
  logic [RS_SIZE-1:0]     rs_valid_issue;
  SQ_MASK                 resolving_sq_mask;
  B_MASK_MASK             b_mm_resolve;
  logic                   b_mm_mispred;
  logic [NUM_LANES-1:0]   ex_ready;
  logic [RS_SIZE-1:0]     rs_data_issuing;
  RS_PACKET               issue_packets [NUM_LANES];
  logic [NUM_LANES-1:0]   issue_valid;

  int checks   = 0;
  int failures = 0;

  issue_select dut (
    .clock             (clock),
    .reset             (reset),
    .rs_data_next      (rs_data_next),
    .rs_valid_issue    (rs_valid_issue),
    .resolving_sq_mask (resolving_sq_mask),
    .b_mm_resolve      (b_mm_resolve),
    .b_mm_mispred      (b_mm_mispred),
    .ex_ready          (ex_ready),
    .rs_data_issuing   (rs_data_issuing),
    .issue_packets     (issue_packets),
    .issue_valid       (issue_valid)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic RS_PACKET mk(input int idx, input logic rd_mem, input SQ_MASK sq,
                                  input B_MASK_MASK b);
    RS_PACKET p;
    p               = '0;
    p.inst          = 32'hA000_0000 | 32'(idx);
    p.dest_tag      = 6'(idx + 16);
    p.Source1_ready = 1'b1;
    p.Source2_ready = 1'b1;
    p.rd_mem        = rd_mem;
    p.sq_mask       = sq;
    p.b_mask        = b;
    return p;
  endfunction

  task automatic idle();
    for (int j = 0; j < RS_SIZE; j++) rs_data_next[j] = mk(j, 1'b0, '0, '0);
    rs_valid_issue    = '0;
    resolving_sq_mask = '0;
    b_mm_resolve      = '0;
    b_mm_mispred      = 1'b0;
    ex_ready          = '0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [RS_SIZE-1:0] prio_exp;
    int                 lo;

    // Reset with a ready entry present: nothing issues, lanes come up empty.
    idle();
    reset           = 1'b1;
    rs_valid_issue  = 8'b0000_0100;
    ex_ready        = 2'b11;
    #1 check("rst_issuing", rs_data_issuing, '0);
    tick();
    tick();
    check("rst_valid", issue_valid, '0);
    check("rst_pkt0", issue_packets[0], '0);
    check("rst_pkt1", issue_packets[1], '0);

    // Entries 1,3,6 ready; 0 and 5 valid but waiting on a source; both lanes empty.
    reset = 1'b0;
    idle();
    rs_data_next[0].Source1_ready = 1'b0;
    rs_data_next[5].Source2_ready = 1'b0;
    rs_valid_issue = 8'b0110_1011;
    #1 check("t1_issuing", rs_data_issuing, 8'b0000_1010);
    tick();
    check("t1_valid", issue_valid, 2'b11);
    check("t1_pkt0", issue_packets[0], mk(1, 1'b0, '0, '0));
    check("t1_pkt1", issue_packets[1], mk(3, 1'b0, '0, '0));

    // Fresh start, then park entry 1 in lane 0.
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rs_valid_issue = 8'b0000_0010;
    #1 check("t2a_issuing", rs_data_issuing, 8'b0000_0010);
    tick();
    check("t2a_valid", issue_valid, 2'b01);

    // Lane 0 stalled, lane 1 free, entries 2 and 5 ready: only entry 2 goes.
    idle();
    rs_valid_issue = 8'b0010_0100;
    #1 check("t2_issuing", rs_data_issuing, 8'b0000_0100);
    tick();
    check("t2_valid", issue_valid, 2'b11);
    check("t2_pkt0", issue_packets[0], mk(1, 1'b0, '0, '0));
    check("t2_pkt1", issue_packets[1], mk(2, 1'b0, '0, '0));

    // Nothing ready, nothing free: everything holds.
    idle();
    #1 check("t3_issuing", rs_data_issuing, '0);
    tick();
    check("t3_valid", issue_valid, 2'b11);
    check("t3_pkt1", issue_packets[1], mk(2, 1'b0, '0, '0));

    // Load lane 1 with a branch-dependent entry.
    idle();
    ex_ready = 2'b11;
    rs_data_next[6] = mk(6, 1'b0, '0, 4'b0010);
    rs_valid_issue  = 8'b0101_0000;
    #1 check("t4_issuing", rs_data_issuing, 8'b0101_0000);
    tick();
    check("t4_pkt0", issue_packets[0], mk(4, 1'b0, '0, '0));
    check("t4_pkt1", issue_packets[1], mk(6, 1'b0, '0, 4'b0010));

    // Branch resolves correctly while lane is stalled: kept, bit cleared.
    idle();
    b_mm_resolve = 4'b0010;
    tick();
    check("t4_ok_valid", issue_valid, 2'b11);
    check("t4_ok_pkt1", issue_packets[1], mk(6, 1'b0, '0, '0));
    check("t4_ok_pkt0", issue_packets[0], mk(4, 1'b0, '0, '0));

    // Reload lane 1 with the dependent entry, then mispredict while stalled.
    idle();
    ex_ready = 2'b10;
    rs_data_next[6] = mk(6, 1'b0, '0, 4'b0010);
    rs_valid_issue  = 8'b0100_0000;
    #1 check("t4b_issuing", rs_data_issuing, 8'b0100_0000);
    tick();
    check("t4b_pkt1", issue_packets[1], mk(6, 1'b0, '0, 4'b0010));
    idle();
    b_mm_resolve = 4'b0010;
    b_mm_mispred = 1'b1;
    tick();
    check("t4_squash_valid", issue_valid, 2'b01);
    check("t4_squash_pkt1", issue_packets[1], '0);
    check("t4_squash_pkt0", issue_packets[0], mk(4, 1'b0, '0, '0));

    // Load whose last store resolves this cycle issues; another load still waits.
    idle();
    ex_ready          = 2'b11;
    rs_data_next[4]   = mk(4, 1'b1, 8'h08, '0);
    rs_data_next[5]   = mk(5, 1'b1, 8'h04, '0);
    rs_valid_issue    = 8'b0011_0000;
    resolving_sq_mask = 8'h08;
    #1 check("t5_issuing", rs_data_issuing, 8'b0001_0000);
    tick();
    check("t5_valid", issue_valid, 2'b01);
    check("t5_pkt0", issue_packets[0], mk(4, 1'b1, '0, '0));

    // Non-load with a store mask issues, then its held mask is cleared by resolution.
    idle();
    ex_ready        = 2'b11;
    rs_data_next[6] = mk(6, 1'b0, 8'h02, '0);
    rs_valid_issue  = 8'b0100_0000;
    #1 check("t6_issuing", rs_data_issuing, 8'b0100_0000);
    tick();
    check("t6_pkt0", issue_packets[0], mk(6, 1'b0, 8'h02, '0));
    idle();
    resolving_sq_mask = 8'h02;
    tick();
    check("t6_hold_valid", issue_valid, 2'b01);
    check("t6_hold_pkt0", issue_packets[0], mk(6, 1'b0, '0, '0));

    // Fill both lanes, then stall both with more ready entries waiting.
    idle();
    ex_ready       = 2'b11;
    rs_valid_issue = 8'b0000_0011;
    #1 check("t7_issuing", rs_data_issuing, 8'b0000_0011);
    tick();
    check("t7_pkt0", issue_packets[0], mk(0, 1'b0, '0, '0));
    check("t7_pkt1", issue_packets[1], mk(1, 1'b0, '0, '0));
    idle();
    rs_valid_issue = 8'b0000_1100;
    #1 check("t7_full_issuing", rs_data_issuing, '0);
    tick();
    check("t7_full_valid", issue_valid, 2'b11);
    check("t7_full_pkt0", issue_packets[0], mk(0, 1'b0, '0, '0));
    check("t7_full_pkt1", issue_packets[1], mk(1, 1'b0, '0, '0));

    // All entries ready every cycle, lanes always free.
    idle();
    reset = 1'b1;
    tick();
    reset          = 1'b0;
    rs_valid_issue = 8'hFF;
    ex_ready       = 2'b11;
    for (int c = 0; c < 5; c++) begin
      lo       = RR_MODE ? (2 * c) % RS_SIZE : 0;
      prio_exp = 8'b0000_0011 << lo;
      #1 check($sformatf("prio%0d_issuing", c), rs_data_issuing, prio_exp);
      tick();
      check($sformatf("prio%0d_pkt0", c), issue_packets[0], mk(lo, 1'b0, '0, '0));
      check($sformatf("prio%0d_pkt1", c), issue_packets[1], mk(lo + 1, 1'b0, '0, '0));
    end

    // Reset while both lanes hold work and three entries are ready.
    idle();
    rs_valid_issue = 8'b0101_0100;
    reset          = 1'b1;
    #1 check("t9_issuing", rs_data_issuing, '0);
    tick();
    check("t9_valid", issue_valid, '0);
    check("t9_pkt0", issue_packets[0], '0);
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/issue_select.md
ISSUE_SELECT -- requirements
Module: issue_select

Interface
REQ-001 SHALL: clock  input  1  clock; all state updates on posedge clock.
REQ-002 SHALL: reset  input  1  reset, synchronous, active-high.
REQ-003 SHALL: rs_data_next  input  RS_PACKET [`RS_SZ]  RS entries after squash, mask resolve and CDB wakeup for this cycle.
REQ-004 SHALL: rs_valid_issue  input  [`RS_SZ]  per-entry valid, excluding entries dispatched this cycle.
REQ-005 SHALL: resolving_sq_mask  input  SQ_MASK  store-queue bits resolving this cycle.
REQ-006 SHALL: b_mm_resolve  input  B_MASK_MASK  branch bit resolving this cycle.
REQ-007 SHALL: b_mm_mispred  input  1  resolving branch mispredicted.
REQ-008 SHALL: ex_ready  input  [`N]  execute lane k accepts the issue_packets[k] currently held.
REQ-009 SHALL: rs_data_issuing  output  [`RS_SZ]  one-hot-per-grant vector of entries leaving the RS this cycle; combinational.
REQ-010 SHALL: issue_packets  output  RS_PACKET [`N]  registered issue-lane contents.
REQ-011 SHALL: issue_valid  output  [`N]  registered lane valid.

Function
REQ-012 SHALL: entry j is ready when rs_valid_issue[j] & Source1_ready & Source2_ready, and, for entries with rd_mem set, (sq_mask & ~resolving_sq_mask) == 0.
REQ-013 SHALL: lane k is free when !issue_valid[k] | ex_ready[k].
REQ-014 SHALL: grant at most (number of free lanes) ready entries per cycle; never grant a non-ready entry; never grant one entry twice.
REQ-015 SHALL: assign grants to free lanes in ascending lane order, earliest-priority grant to lowest free lane.
REQ-016 SHALL: assert rs_data_issuing[j] in the same cycle entry j is granted; entry appears on issue_packets next cycle (1-cycle latency).
REQ-017 SHALL: a non-free lane (valid, !ex_ready) hold issue_packets[k] and issue_valid[k] unchanged except REQ-018/019.
REQ-018 SHALL: each cycle, clear b_mm_resolve bits from every held lane b_mask and clear resolving_sq_mask bits from every held lane sq_mask.
REQ-019 SHALL: when b_mm_mispred and (b_mask & b_mm_resolve) != 0 for a held lane, clear issue_valid[k] and zero issue_packets[k] next cycle, even if ex_ready[k] is low.
REQ-020 SHALL: a free lane receiving no grant become invalid with packet zeroed next cycle.
REQ-021 SHALL: with zero ready entries or zero free lanes, rs_data_issuing = 0 and state other than REQ-018/019/020 hold.
REQ-022 SHALL: packets latched into lanes carry the masks already resolved in rs_data_next, with resolving_sq_mask also applied.

Reset
REQ-023 SHALL: on reset, issue_valid = 0, issue_packets = 0, priority pointer = 0; rs_data_issuing = 0 during reset cycles.
REQ-024 SHALL: reset mid-operation discard all held lanes with no grant issued that cycle.

Configuration
REQ-025 SHALL: ISSUE_RR_PRIORITY_EN defined -> round-robin priority: search starts at rr_ptr, wraps at `RS_SZ-1 to 0; after any grant cycle rr_ptr = (highest-priority-order last granted index + 1) mod `RS_SZ; unchanged with no grant.
REQ-026 SHALL: ISSUE_RR_PRIORITY_EN undefined -> fixed priority, lowest index first; no pointer register.

Structure
REQ-027 SHALL: RS_PACKET, SQ_MASK, B_MASK_MASK, `N, `RS_SZ come from sys_defs.svh; a new ISSUE_LANE typedef (valid + RS_PACKET) is added there.
REQ-028 SHALL: grant selection reside in sub-module issue_rr_arb (parameters WIDTH=`RS_SZ, REQS=`N), with the rotation logic inside ISSUE_RR_PRIORITY_EN.
REQ-029 SHALL: remain 120-400 RTL lines total.

Verification (bench: N=2, RS_SZ=8)
REQ-030 SHALL: entries 1,3,6 ready, lanes empty, fixed priority -> rs_data_issuing=8'b0000_1010; next cycle lane0=entry1, lane1=entry3, issue_valid=2'b11.
REQ-031 SHALL: lane0 valid, ex_ready=2'b00, lane1 empty, entries 2,5 ready -> rs_data_issuing=8'b0000_0100; lane0 unchanged, lane1=entry2.
REQ-032 SHALL: lane1 b_mask=4'b0010, ex_ready=0, b_mm_resolve=4'b0010, b_mm_mispred=1 -> issue_valid[1]=0 next cycle; with mispred=0 -> lane kept, b_mask=0.
REQ-033 SHALL: load entry 4 ready except sq_mask=bit3, resolving_sq_mask=bit3 same cycle -> entry 4 granted this cycle with sq_mask=0 in lane.
REQ-034 SHALL: ISSUE_RR_PRIORITY_EN, all 8 entries ready every cycle, lanes always free -> grant pairs {0,1},{2,3},{4,5},{6,7},{0,1}.
REQ-035 SHALL: reset asserted with both lanes valid and 3 ready entries -> rs_data_issuing=0 and issue_valid=0 next cycle.
